// File: rtl/busca_fronteira.sv
// busca_fronteira: searches a square occupancy grid for the nearest frontier cell
// around the robot, ring by ring in Manhattan distance, and reports the first hit.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   inicio, cancelar             start pulse (ignored while busy), abort request
//   posicaoAtualnoEixoX/Y        robot cell, latched when inicio is accepted
//   enable[3:0]                  quadrant mask: direitaFrente, esquerdaFrente,
//                                esquerdaTras, direitaTras
//   endereco, enderecoValido     grid read address (y*TamanhoMalha+x) and strobe
//   dadoMalha                    cell value, valid the cycle after the strobe
//   ocupado                      search in progress
//   operacaoFinalizada           one-cycle pulse when a search completes
//   encontrado, destinoX/Y,      result of the last completed search
//   distancia
module busca_fronteira #(
    parameter int TamanhoMalha     = 20,
    parameter int tamanhoDistancia = 8,
    parameter int RaioMaximo       = 2 * TamanhoMalha - 2,
    localparam int LARG_END        = $clog2(TamanhoMalha * TamanhoMalha)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        inicio,
    input  logic                        cancelar,
    input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
    input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
    input  logic [3:0]                  enable,
    output logic [LARG_END-1:0]         endereco,
    output logic                        enderecoValido,
    input  logic [1:0]                  dadoMalha,
    output logic                        ocupado,
    output logic                        operacaoFinalizada,
    output logic                        encontrado,
    output logic [tamanhoDistancia-1:0] destinoX,
    output logic [tamanhoDistancia-1:0] destinoY,
    output logic [tamanhoDistancia-1:0] distancia
);

    // Two extra bits: one for sign, one so pos+offset never wraps.
    localparam int LARG_COORD = tamanhoDistancia + 2;
    typedef logic signed [LARG_COORD-1:0] coord_t;

    localparam coord_t     C_MALHA   = coord_t'(TamanhoMalha);
    localparam coord_t     C_RMAX    = coord_t'(RaioMaximo);
    localparam coord_t     C_UM      = coord_t'(1);
    localparam logic [1:0] FRONTEIRA = 2'b11;

    typedef enum logic [1:0] {IDLE, GERAR, COMPARAR, FIM} estado_t;

    estado_t                     r_estado, w_estado_prox;
    coord_t                      r_raio, w_raio_prox;
    coord_t                      r_dx, w_dx_prox;
    coord_t                      r_dy, w_dy_prox;
    coord_t                      r_pos_x, w_pos_x_prox;
    coord_t                      r_pos_y, w_pos_y_prox;
    logic [3:0]                  r_enable, w_enable_prox;
    logic                        r_encontrado, w_encontrado_prox;
    logic [tamanhoDistancia-1:0] r_destino_x, w_destino_x_prox;
    logic [tamanhoDistancia-1:0] r_destino_y, w_destino_y_prox;
    logic [tamanhoDistancia-1:0] r_distancia, w_distancia_prox;

    coord_t     w_abs_dx, w_k, w_dx_inc, w_abs_dx_inc, w_k_inc;
    coord_t     w_cand_x, w_cand_y;
    coord_t     w_av_raio, w_av_dx, w_av_dy;
    logic       w_av_fim;
    logic       w_dentro, w_habilitado, w_le;
    logic [1:0] w_quad;
    int         w_end_int;

    // Current candidate in absolute grid coordinates.
    assign w_cand_x = r_pos_x + r_dx;
    assign w_cand_y = r_pos_y + r_dy;
    assign w_dentro = (w_cand_x >= 0) && (w_cand_x < C_MALHA) &&
                      (w_cand_y >= 0) && (w_cand_y < C_MALHA);

    always_comb begin
        if (r_dx > 0 && r_dy >= 0) begin
            w_quad = 2'd0;
        end else if (r_dx <= 0 && r_dy > 0) begin
            w_quad = 2'd1;
        end else if (r_dx < 0 && r_dy <= 0) begin
            w_quad = 2'd2;
        end else begin
            w_quad = 2'd3;
        end
    end

    assign w_habilitado = r_enable[w_quad];
    assign w_le         = (r_estado == GERAR) && w_dentro && w_habilitado;
    assign w_end_int    = int'(w_cand_y) * TamanhoMalha + int'(w_cand_x);

    // Ring walk: k = r-|dx| gives the two dy values (-k then +k) for each dx.
    assign w_abs_dx     = r_dx[LARG_COORD-1] ? -r_dx : r_dx;
    assign w_k          = r_raio - w_abs_dx;
    assign w_dx_inc     = r_dx + C_UM;
    assign w_abs_dx_inc = w_dx_inc[LARG_COORD-1] ? -w_dx_inc : w_dx_inc;
    assign w_k_inc      = r_raio - w_abs_dx_inc;

    always_comb begin
        w_av_fim  = 1'b0;
        w_av_raio = r_raio;
        w_av_dx   = r_dx;
        w_av_dy   = r_dy;
        if (w_k != '0 && r_dy < 0) begin
            w_av_dy = w_k;
        end else if (r_dx != r_raio) begin
            w_av_dx = w_dx_inc;
            w_av_dy = -w_k_inc;
        end else if (r_raio < C_RMAX) begin
            w_av_raio = r_raio + C_UM;
            w_av_dx   = -(r_raio + C_UM);
            w_av_dy   = '0;
        end else begin
            w_av_fim = 1'b1;
        end
    end

    always_comb begin
        w_estado_prox     = r_estado;
        w_raio_prox       = r_raio;
        w_dx_prox         = r_dx;
        w_dy_prox         = r_dy;
        w_pos_x_prox      = r_pos_x;
        w_pos_y_prox      = r_pos_y;
        w_enable_prox     = r_enable;
        w_encontrado_prox = r_encontrado;
        w_destino_x_prox  = r_destino_x;
        w_destino_y_prox  = r_destino_y;
        w_distancia_prox  = r_distancia;

        // Abort wins over everything and leaves results untouched.
        if (cancelar && r_estado != IDLE) begin
            w_estado_prox = IDLE;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (inicio) begin
                        w_pos_x_prox      = coord_t'(posicaoAtualnoEixoX);
                        w_pos_y_prox      = coord_t'(posicaoAtualnoEixoY);
                        w_enable_prox     = enable;
                        w_raio_prox       = C_UM;
                        w_dx_prox         = -C_UM;
                        w_dy_prox         = '0;
                        w_encontrado_prox = 1'b0;
                        w_destino_x_prox  = '0;
                        w_destino_y_prox  = '0;
                        w_distancia_prox  = '0;
                        w_estado_prox     = GERAR;
                    end
                end
                GERAR: begin
                    if (w_le) begin
                        w_estado_prox = COMPARAR;
                    end else if (w_av_fim) begin
                        w_encontrado_prox = 1'b0;
                        w_destino_x_prox  = '0;
                        w_destino_y_prox  = '0;
                        w_distancia_prox  = '0;
                        w_estado_prox     = FIM;
                    end else begin
                        w_raio_prox = w_av_raio;
                        w_dx_prox   = w_av_dx;
                        w_dy_prox   = w_av_dy;
                    end
                end
                COMPARAR: begin
                    if (dadoMalha == FRONTEIRA) begin
                        w_encontrado_prox = 1'b1;
                        w_destino_x_prox  = w_cand_x[tamanhoDistancia-1:0];
                        w_destino_y_prox  = w_cand_y[tamanhoDistancia-1:0];
                        w_distancia_prox  = r_raio[tamanhoDistancia-1:0];
                        w_estado_prox     = FIM;
                    end else if (w_av_fim) begin
                        w_encontrado_prox = 1'b0;
                        w_destino_x_prox  = '0;
                        w_destino_y_prox  = '0;
                        w_distancia_prox  = '0;
                        w_estado_prox     = FIM;
                    end else begin
                        w_raio_prox   = w_av_raio;
                        w_dx_prox     = w_av_dx;
                        w_dy_prox     = w_av_dy;
                        w_estado_prox = GERAR;
                    end
                end
                FIM: begin
                    w_estado_prox = IDLE;
                end
                default: begin
                    w_estado_prox = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado     <= IDLE;
            r_raio       <= C_UM;
            r_dx         <= '0;
            r_dy         <= '0;
            r_pos_x      <= '0;
            r_pos_y      <= '0;
            r_enable     <= '0;
            r_encontrado <= 1'b0;
            r_destino_x  <= '0;
            r_destino_y  <= '0;
            r_distancia  <= '0;
        end else begin
            r_estado     <= w_estado_prox;
            r_raio       <= w_raio_prox;
            r_dx         <= w_dx_prox;
            r_dy         <= w_dy_prox;
            r_pos_x      <= w_pos_x_prox;
            r_pos_y      <= w_pos_y_prox;
            r_enable     <= w_enable_prox;
            r_encontrado <= w_encontrado_prox;
            r_destino_x  <= w_destino_x_prox;
            r_destino_y  <= w_destino_y_prox;
            r_distancia  <= w_distancia_prox;
        end
    end

    assign enderecoValido     = w_le;
    assign endereco           = w_le ? w_end_int[LARG_END-1:0] : '0;
    assign ocupado            = (r_estado != IDLE);
    assign operacaoFinalizada = (r_estado == FIM);
    assign encontrado         = r_encontrado;
    assign destinoX           = r_destino_x;
    assign destinoY           = r_destino_y;
    assign distancia          = r_distancia;

endmodule

// File: doc/busca_fronteira.md
BUSCA_FRONTEIRA -- requirements
Module: busca_fronteira

Interface
REQ-001 SHALL have parameter TamanhoMalha, default 20, meaning grid side in cells (grid is TamanhoMalha x TamanhoMalha).
REQ-002 SHALL have parameter tamanhoDistancia, default 8, meaning bit width of coordinates and distance.
REQ-003 SHALL have parameter RaioMaximo, default 2*TamanhoMalha-2, meaning largest Manhattan radius searched.
REQ-004 SHALL derive localparam LARG_END = $clog2(TamanhoMalha*TamanhoMalha), meaning address width.
REQ-005 SHALL have ports: clock in 1, rising-edge clock; reset in 1, synchronous and active-high.
REQ-006 SHALL have ports: inicio in 1, start pulse; cancelar in 1, abort request.
REQ-007 SHALL have ports: posicaoAtualnoEixoX and posicaoAtualnoEixoY, both in tamanhoDistancia, robot cell.
REQ-008 SHALL have port enable in 4, quadrant mask: bit0 direitaFrente, bit1 esquerdaFrente, bit2 esquerdaTras, bit3 direitaTras.
REQ-009 SHALL have ports: endereco out LARG_END, cell address y*TamanhoMalha+x; enderecoValido out 1, read strobe.
REQ-010 SHALL have port dadoMalha in 2, cell value valid one cycle after its strobe: 00 unknown, 01 free, 10 occupied, 11 frontier.
REQ-011 SHALL have ports: ocupado out 1; operacaoFinalizada out 1, one-cycle pulse; encontrado out 1.
REQ-012 SHALL have ports: destinoX, destinoY and distancia, all out tamanhoDistancia.

Function
REQ-013 SHALL use states IDLE, GERAR, COMPARAR, FIM.
REQ-014 IDLE: when inicio=1, SHALL latch the position and enable, set r=1, set the first candidate of ring 1, set ocupado=1, and go to GERAR. When inicio=0, SHALL remain in IDLE.
REQ-015 The ring of radius r SHALL be scanned with dx ascending from -r to +r. For each dx, with k=r-|dx|: visit dy=-k, then dy=+k. When k=0, visit one cell only.
REQ-016 Quadrant of offset (dx,dy): direitaFrente when dx>0,dy>=0; esquerdaFrente when dx<=0,dy>0; esquerdaTras when dx<0,dy<=0; direitaTras when dx>=0,dy<0.
REQ-017 GERAR: if the candidate is inside 0..TamanhoMalha-1 on both axes and its quadrant bit is set, SHALL assert enderecoValido with its endereco for exactly that cycle and go to COMPARAR. Otherwise SHALL advance the candidate in the same cycle without a read (1 cycle per skipped cell).
REQ-018 COMPARAR: if dadoMalha==11, SHALL set encontrado=1, destinoX/Y=candidate, distancia=r, and go to FIM. Otherwise SHALL advance the candidate and return to GERAR.
REQ-019 Advancing past the last cell of ring r: if r<RaioMaximo, SHALL set r=r+1 and start at dx=-r. If r==RaioMaximo, SHALL go to FIM with encontrado=0 and destinoX, destinoY, distancia=0.
REQ-020 FIM: SHALL pulse operacaoFinalizada for one cycle, clear ocupado, and go to IDLE. Results SHALL hold until the next inicio is accepted.
REQ-021 SHALL stop at the first frontier found; ties at equal distance SHALL be resolved by REQ-015 order.
REQ-022 When enable=0000, SHALL issue no reads and SHALL finish through FIM with encontrado=0.
REQ-023 SHALL ignore inicio while ocupado=1.
REQ-024 cancelar=1 in any non-IDLE state SHALL return to IDLE next cycle with ocupado=0, no operacaoFinalizada pulse, and results unchanged. cancelar SHALL have priority over all transitions.
REQ-025 Coordinate arithmetic SHALL use signed width tamanhoDistancia+2 so that negative and overflowing candidates are detected, never wrapped.
REQ-026 enderecoValido SHALL never be asserted for an out-of-grid cell.
REQ-027 encontrado and destinoX/Y/distancia SHALL be cleared when inicio is accepted.

Reset
REQ-028 reset=1 on a clock edge SHALL force IDLE with every output 0, including mid-search; r SHALL be 1.
REQ-029 No operacaoFinalizada pulse SHALL occur as a consequence of reset.

Verification
REQ-030 T=8, position (3,3), enable=1111, only cell (5,3)=11 -> operacaoFinalizada pulses; encontrado=1, destino (5,3), distancia=2.
REQ-031 T=8, position (3,3), cells (2,3) and (4,3)=11 -> destino (2,3), distancia=1 (tie-break).
REQ-032 T=8, position (3,3), enable=0001, cells (2,3) and (6,3)=11 -> destino (6,3), distancia=3; no reads at dx<=0.
REQ-033 T=8, position (0,0), no frontier, RaioMaximo=14 -> encontrado=0, destino (0,0), distancia=0; enderecoValido never addresses x>7 or y>7.
REQ-034 During search: inicio ignored; then cancelar=1 -> IDLE next cycle, ocupado=0, no operacaoFinalizada; new inicio accepted afterward.
REQ-035 reset asserted while in COMPARAR -> next cycle all outputs 0, state IDLE; no pulse.
